// File: rtl/mem_arbiter.sv
// Arbitrates the byte-serial memory controller between instruction fetch and the load/store
// buffer: one transaction in flight, IO-store gating, fetch anti-starvation, flush discard.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter logic [31:0] IO_BASE      = 32'h0003_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_in,
  input  logic        if_req_in,
  input  logic [31:0] if_addr_in,
  output logic        if_ready_out,
  output logic [31:0] if_ins_out,
  input  logic        ls_req_in,
  input  logic [31:0] ls_addr_in,
  input  logic [31:0] ls_data_in,
  input  logic [3:0]  ls_op_in,
  output logic        ls_ready_out,
  output logic [31:0] ls_val_out,
  input  logic        io_buffer_full,
  output logic        mc_req_out,
  output logic [31:0] mc_addr_out,
  output logic [31:0] mc_data_out,
  output logic [3:0]  mc_op_out,
  input  logic        mc_done_in,
  input  logic [31:0] mc_rdata_in,
  output logic        busy_out
);

  localparam logic [3:0] StarveLim = 4'(STARVE_LIMIT);
  localparam logic [3:0] OpFetch   = 4'b0010;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e      state_q;
  logic        owner_ls_q;
  logic        is_store_q;
  logic        discard_q;
  logic [3:0]  streak_q;
  logic [3:0]  streak_d;
  logic        mc_req_q;
  logic [31:0] mc_addr_q;
  logic [31:0] mc_data_q;
  logic [3:0]  mc_op_q;
  logic [31:0] if_ins_q;
  logic [31:0] ls_val_q;

  logic io_blocked;
  logic ls_ok;
  logic if_ok;
  logic grant_if;
  logic grant_ls;
  logic kill;
  logic resp_ok;

  always_comb begin
    // Stores survive a flush; fetches and loads presented during a flush are dropped.
    io_blocked = ls_op_in[3] && (ls_addr_in >= IO_BASE) && io_buffer_full;
    ls_ok      = ls_req_in && !io_blocked && (ls_op_in[3] || !flush_in);
    if_ok      = if_req_in && !flush_in;
    grant_if   = (state_q == StIdle) && if_ok && (!ls_ok || (streak_q == StarveLim));
    grant_ls   = (state_q == StIdle) && ls_ok && !grant_if;
    kill       = flush_in && !is_store_q;

    streak_d = streak_q;
    if (!if_req_in || grant_if) begin
      streak_d = 4'd0;
    end else if (grant_ls && (streak_q != StarveLim)) begin
      streak_d = streak_q + 4'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= StIdle;
      owner_ls_q <= 1'b0;
      is_store_q <= 1'b0;
      discard_q  <= 1'b0;
      streak_q   <= 4'd0;
      mc_req_q   <= 1'b0;
      mc_addr_q  <= 32'd0;
      mc_data_q  <= 32'd0;
      mc_op_q    <= 4'd0;
      if_ins_q   <= 32'd0;
      ls_val_q   <= 32'd0;
    end else if (rdy_in) begin
      streak_q <= streak_d;
      unique case (state_q)
        StIdle: begin
          if (grant_if) begin
            owner_ls_q <= 1'b0;
            is_store_q <= 1'b0;
            discard_q  <= 1'b0;
            mc_req_q   <= 1'b1;
            mc_addr_q  <= if_addr_in;
            mc_data_q  <= 32'd0;
            mc_op_q    <= OpFetch;
            state_q    <= StIssue;
          end else if (grant_ls) begin
            owner_ls_q <= 1'b1;
            is_store_q <= ls_op_in[3];
            discard_q  <= 1'b0;
            mc_req_q   <= 1'b1;
            mc_addr_q  <= ls_addr_in;
            mc_data_q  <= ls_data_in;
            mc_op_q    <= ls_op_in;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          mc_req_q <= 1'b0;
          if (kill) discard_q <= 1'b1;
          state_q <= StWait;
        end
        StWait: begin
          if (mc_done_in) begin
            if (discard_q || kill) begin
              state_q <= StIdle;
            end else begin
              if (owner_ls_q) ls_val_q <= mc_rdata_in;
              else            if_ins_q <= mc_rdata_in;
              state_q <= StResp;
            end
          end else if (kill) begin
            discard_q <= 1'b1;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Ready is qualified in RESP so a flush arriving there can still suppress it.
  assign resp_ok      = rdy_in && (state_q == StResp) && !kill;
  assign if_ready_out = resp_ok && !owner_ls_q;
  assign ls_ready_out = resp_ok && owner_ls_q;
  assign if_ins_out   = if_ins_q;
  assign ls_val_out   = ls_val_q;
  assign mc_req_out   = mc_req_q;
  assign mc_addr_out  = mc_addr_q;
  assign mc_data_out  = mc_data_q;
  assign mc_op_out    = mc_op_q;
  assign busy_out     = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency controller model and manual override.
module tb_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        flush_in = 1'b0;
  logic        if_req_in = 1'b0;
  logic [31:0] if_addr_in = '0;
  logic        if_ready_out;
  logic [31:0] if_ins_out;
  logic        ls_req_in = 1'b0;
  logic [31:0] ls_addr_in = '0;
  logic [31:0] ls_data_in = '0;
  logic [3:0]  ls_op_in = '0;
  logic        ls_ready_out;
  logic [31:0] ls_val_out;
  logic        io_buffer_full = 1'b0;
  logic        mc_req_out;
  logic [31:0] mc_addr_out;
  logic [31:0] mc_data_out;
  logic [3:0]  mc_op_out;
  logic        mc_done_in;
  logic [31:0] mc_rdata_in;
  logic        busy_out;

  logic        auto_mc = 1'b1;
  logic        auto_done;
  logic [31:0] auto_rdata;
  logic [1:0]  cnt;
  logic        man_done = 1'b0;
  logic [31:0] man_rdata = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_in = ~clk_in;

  mem_arbiter #(.STARVE_LIMIT(4), .IO_BASE(32'h0003_0000)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .flush_in      (flush_in),
    .if_req_in     (if_req_in),
    .if_addr_in    (if_addr_in),
    .if_ready_out  (if_ready_out),
    .if_ins_out    (if_ins_out),
    .ls_req_in     (ls_req_in),
    .ls_addr_in    (ls_addr_in),
    .ls_data_in    (ls_data_in),
    .ls_op_in      (ls_op_in),
    .ls_ready_out  (ls_ready_out),
    .ls_val_out    (ls_val_out),
    .io_buffer_full(io_buffer_full),
    .mc_req_out    (mc_req_out),
    .mc_addr_out   (mc_addr_out),
    .mc_data_out   (mc_data_out),
    .mc_op_out     (mc_op_out),
    .mc_done_in    (mc_done_in),
    .mc_rdata_in   (mc_rdata_in),
    .busy_out      (busy_out)
  );

  assign mc_done_in  = auto_mc ? auto_done  : man_done;
  assign mc_rdata_in = auto_mc ? auto_rdata : man_rdata;

  // Controller model: done two cycles after the request pulse, data = addr ^ 0x5A5A0000.
  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt        <= 2'd0;
      auto_done  <= 1'b0;
      auto_rdata <= 32'd0;
    end else if (rdy_in) begin
      auto_done <= 1'b0;
      if (mc_req_out) begin
        cnt <= 2'd2;
      end else if (cnt != 2'd0) begin
        cnt <= cnt - 2'd1;
        if (cnt == 2'd1) begin
          auto_done  <= 1'b1;
          auto_rdata <= mc_addr_out ^ 32'h5A5A_0000;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_ready(input string tag, output logic is_ls);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk_in);
      if (if_ready_out || ls_ready_out) seen = 1'b1;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    is_ls = ls_ready_out;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic w;

    // Reset state
    repeat (2) cyc();
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_mc_req", 32'(mc_req_out), 32'd0);
    check("rst_mc_addr", mc_addr_out, 32'd0);
    check("rst_mc_op", 32'(mc_op_out), 32'd0);
    check("rst_if_ready", 32'(if_ready_out), 32'd0);
    check("rst_ls_ready", 32'(ls_ready_out), 32'd0);
    check("rst_ls_val", ls_val_out, 32'd0);
    rst_in = 1'b1;
    cyc();

    // Simultaneous fetch and load: LSB first
    if_req_in = 1'b1; if_addr_in = 32'h1000;
    ls_req_in = 1'b1; ls_addr_in = 32'h100; ls_op_in = 4'b0010;
    cyc();
    check("t2_busy", 32'(busy_out), 32'd1);
    check("t2_mc_req", 32'(mc_req_out), 32'd1);
    check("t2_mc_addr", mc_addr_out, 32'h100);
    check("t2_mc_op", 32'(mc_op_out), 32'h2);
    wait_ready("t2_r1", w);
    check("t2_first_is_ls", 32'(w), 32'd1);
    check("t2_ls_val", ls_val_out, 32'h5A5A_0100);
    cyc();
    ls_req_in = 1'b0;
    wait_ready("t2_r2", w);
    check("t2_second_is_if", 32'(w), 32'd0);
    check("t2_if_ins", if_ins_out, 32'h5A5A_1000);
    check("t2_fetch_op", 32'(mc_op_out), 32'h2);
    cyc();
    if_req_in = 1'b0;

    // Starvation: four LSB grants, then fetch
    if_req_in = 1'b1; if_addr_in = 32'h2000;
    ls_req_in = 1'b1; ls_addr_in = 32'h300; ls_op_in = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      wait_ready($sformatf("t3_r%0d", i), w);
      check($sformatf("t3_grant%0d_is_ls", i), 32'(w), (i < 4) ? 32'd1 : 32'd0);
    end
    check("t3_if_ins", if_ins_out, 32'h5A5A_2000);
    cyc();
    if_req_in = 1'b0; ls_req_in = 1'b0;
    cyc();
    check("t3_idle", 32'(busy_out), 32'd0);

    // Blocked IO store lets fetch through
    io_buffer_full = 1'b1;
    ls_req_in = 1'b1; ls_addr_in = 32'h0003_0000; ls_data_in = 32'h41; ls_op_in = 4'b1000;
    if_req_in = 1'b1; if_addr_in = 32'h3000;
    cyc();
    check("t4_fetch_addr", mc_addr_out, 32'h3000);
    check("t4_fetch_op", 32'(mc_op_out), 32'h2);
    wait_ready("t4_r1", w);
    check("t4_fetch_done", 32'(w), 32'd0);
    cyc();
    if_req_in = 1'b0;
    repeat (3) cyc();
    check("t4_store_blocked", 32'(busy_out), 32'd0);
    io_buffer_full = 1'b0;
    cyc();
    check("t4_st_req", 32'(mc_req_out), 32'd1);
    check("t4_st_addr", mc_addr_out, 32'h0003_0000);
    check("t4_st_op", 32'(mc_op_out), 32'h8);
    check("t4_st_data", mc_data_out, 32'h41);
    wait_ready("t4_r2", w);
    check("t4_store_done", 32'(w), 32'd1);
    cyc();
    ls_req_in = 1'b0;

    // Fetch flushed in WAIT
    auto_mc = 1'b0;
    if_req_in = 1'b1; if_addr_in = 32'h4000;
    cyc();
    cyc();
    flush_in = 1'b1;
    cyc();
    flush_in = 1'b0; if_req_in = 1'b0;
    cyc();
    check("t5_still_busy", 32'(busy_out), 32'd1);
    man_done = 1'b1; man_rdata = 32'hBAD0_BAD0;
    @(negedge clk_in);
    check("t5_no_ready_a", 32'(if_ready_out), 32'd0);
    cyc();
    man_done = 1'b0;
    check("t5_idle", 32'(busy_out), 32'd0);
    @(negedge clk_in);
    check("t5_no_ready_b", 32'(if_ready_out), 32'd0);
    check("t5_if_ins_kept", if_ins_out, 32'h5A5A_3000);

    // Flush coincident with done
    cyc();
    if_req_in = 1'b1; if_addr_in = 32'h4400;
    cyc();
    cyc();
    flush_in = 1'b1; man_done = 1'b1; man_rdata = 32'h1111_2222;
    @(negedge clk_in);
    check("t6_no_ready_a", 32'(if_ready_out), 32'd0);
    cyc();
    flush_in = 1'b0; man_done = 1'b0; if_req_in = 1'b0;
    check("t6_idle", 32'(busy_out), 32'd0);
    @(negedge clk_in);
    check("t6_no_ready_b", 32'(if_ready_out), 32'd0);

    // Store flushed in WAIT still completes
    cyc();
    ls_req_in = 1'b1; ls_addr_in = 32'h200; ls_data_in = 32'hDEAD_BEEF; ls_op_in = 4'b1010;
    cyc();
    cyc();
    flush_in = 1'b1;
    cyc();
    flush_in = 1'b0; man_done = 1'b1; man_rdata = 32'd0;
    cyc();
    man_done = 1'b0;
    @(negedge clk_in);
    check("t7_st_ready", 32'(ls_ready_out), 32'd1);
    check("t7_st_data", mc_data_out, 32'hDEAD_BEEF);
    check("t7_st_addr", mc_addr_out, 32'h200);
    cyc();
    ls_req_in = 1'b0;
    @(negedge clk_in);
    check("t7_single_pulse", 32'(ls_ready_out), 32'd0);
    check("t7_idle", 32'(busy_out), 32'd0);

    // Flush in RESP suppresses load pulse
    cyc();
    ls_req_in = 1'b1; ls_addr_in = 32'h600; ls_op_in = 4'b0010;
    cyc();
    cyc();
    man_done = 1'b1; man_rdata = 32'h600D;
    cyc();
    man_done = 1'b0; flush_in = 1'b1;
    @(negedge clk_in);
    check("t8_no_ready", 32'(ls_ready_out), 32'd0);
    cyc();
    flush_in = 1'b0; ls_req_in = 1'b0;
    check("t8_idle", 32'(busy_out), 32'd0);

    // rdy_in low freezes WAIT and ignores done
    ls_req_in = 1'b1; ls_addr_in = 32'h500; ls_op_in = 4'b0010;
    cyc();
    cyc();
    rdy_in = 1'b0; man_done = 1'b1; man_rdata = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check($sformatf("t9_frozen_busy%0d", i), 32'(busy_out), 32'd1);
      check($sformatf("t9_frozen_addr%0d", i), mc_addr_out, 32'h500);
    end
    rdy_in = 1'b1; man_done = 1'b0;
    @(negedge clk_in);
    check("t9_not_captured", 32'(ls_ready_out), 32'd0);
    cyc();
    check("t9_still_wait", 32'(busy_out), 32'd1);
    man_done = 1'b1; man_rdata = 32'h5678;
    cyc();
    man_done = 1'b0;
    @(negedge clk_in);
    check("t9_ready", 32'(ls_ready_out), 32'd1);
    check("t9_val", ls_val_out, 32'h5678);
    cyc();
    ls_req_in = 1'b0;

    // Async reset mid-transaction
    ls_req_in = 1'b1; ls_addr_in = 32'h700; ls_op_in = 4'b0010;
    cyc();
    cyc();
    #2;
    rst_in = 1'b0;
    #1;
    check("t10_busy", 32'(busy_out), 32'd0);
    check("t10_mc_addr", mc_addr_out, 32'd0);
    check("t10_ls_ready", 32'(ls_ready_out), 32'd0);
    ls_req_in = 1'b0;
    cyc();
    rst_in = 1'b1;
    cyc();
    check("t10_after_busy", 32'(busy_out), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
